// File: rtl/alu_exec_stage_pkg.sv
// Shared types and constants for the ALU execute stage.
//  - ALU_XLEN / ALU_OP_W / RD_W : datapath, op-code and register-index widths
//  - alu_op_e                   : ALU op-code encoding understood by the external ALU
//  - e_data_t                   : contents of the E (operand) register
//  - w_data_t                   : contents of the W (result) register
package alu_exec_stage_pkg;

  localparam int ALU_XLEN = 32;
  localparam int ALU_OP_W = 4;
  localparam int RD_W     = 5;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_EQ   = 4'd10,
    ALU_NE   = 4'd11
  } alu_op_e;

  // Op code is carried as raw bits so that any decoded value reaches the ALU untouched.
  typedef struct packed {
    logic [ALU_OP_W-1:0] op;
    logic                is_cond;
    logic [ALU_XLEN-1:0] a;
    logic [ALU_XLEN-1:0] b;
    logic [ALU_XLEN-1:0] imm;
    logic [ALU_XLEN-1:0] pc;
    logic [RD_W-1:0]     rd;
  } e_data_t;

  typedef struct packed {
    logic [RD_W-1:0]     rd;
    logic [ALU_XLEN-1:0] data;
    logic                wen;
    logic                br_taken;
    logic [ALU_XLEN-1:0] br_target;
  } w_data_t;

endpackage

// File: rtl/alu_exec_stage_pipe_reg.sv
// Single-entry valid/ready register slice, used for both the E and W stages.
// No skid buffer: in_ready is a combinational function of the downstream ready.
//  clk, rst_n            : clock, synchronous active-low reset (clears valid and data)
//  flush                 : drops the held entry and any entry offered this cycle
//  in_valid/in_ready/in_data    : upstream handshake
//  out_valid/out_ready/out_data : downstream handshake; out_data stable while stalled
module alu_exec_stage_pipe_reg #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  // Slot is free if empty or being drained this cycle.
  assign in_ready = !out_valid || out_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  //       pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      // NOTE: data is reset too (not just valid) so everything fed from it
      //       reads as zero after reset instead of X.
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      // Data only changes on a real load, so consumers see no glitching.
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute-stage driver for an external combinational ALU.
// Accepts decoded ops over valid/ready, registers operands in E (which drives the
// ALU), and captures the ALU result plus branch information in W for writeback.
//  clk, rst_n, flush          : clock, sync active-low reset, pipeline kill
//  in_valid/in_ready, in_*    : decoded op from decode
//  alu_a/alu_b/alu_op/alu_is_cond : ALU operand ports, driven from E
//  alu_result                 : combinational result from the ALU
//  out_valid/out_ready, out_* : result to writeback / branch logic
//  stall_cnt                  : saturating count of cycles E was blocked by W
module alu_exec_stage
  import alu_exec_stage_pkg::*;
#(
  parameter int XLEN    = ALU_XLEN,   // must match ALU_XLEN
  parameter int OP_W    = ALU_OP_W,   // must match ALU_OP_W
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    in_op,
  input  logic               in_is_cond,
  input  logic [XLEN-1:0]    in_rs1,
  input  logic [XLEN-1:0]    in_rs2,
  input  logic [XLEN-1:0]    in_imm,
  input  logic               in_use_imm,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [RD_W-1:0]    in_rd,
  output logic [XLEN-1:0]    alu_a,
  output logic [XLEN-1:0]    alu_b,
  output logic [OP_W-1:0]    alu_op,
  output logic               alu_is_cond,
  input  logic [XLEN-1:0]    alu_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RD_W-1:0]    out_rd,
  output logic [XLEN-1:0]    out_data,
  output logic               out_wen,
  output logic               out_br_taken,
  output logic [XLEN-1:0]    out_br_target,
  output logic [STALL_W-1:0] stall_cnt
);

  e_data_t e_in, e_q;
  w_data_t w_in, w_q;
  logic    e_valid;
  logic    w_accept;

  // Operand selection at accept time. Branch compares always use rs2 as b;
  // the immediate travels separately for the target adder.
  always_comb begin
    // NOTE: default first so no path leaves a field unassigned (no latch).
    e_in         = '0;
    e_in.op      = in_op;
    e_in.is_cond = in_is_cond;
    e_in.a       = in_rs1;
    e_in.b       = (in_use_imm && !in_is_cond) ? in_imm : in_rs2;
    e_in.imm     = in_imm;
    e_in.pc      = in_pc;
    e_in.rd      = in_rd;
  end

  alu_exec_stage_pipe_reg #(.T(e_data_t)) u_e_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (e_in),
    .out_valid (e_valid),
    .out_ready (w_accept),
    .out_data  (e_q)
  );

  assign alu_a       = e_q.a;
  assign alu_b       = e_q.b;
  assign alu_op      = e_q.op;
  assign alu_is_cond = e_q.is_cond;

  // Result formatting: branches write no register and report taken/target;
  // ordinary ops report no branch. Target wraps modulo 2^XLEN.
  always_comb begin
    w_in           = '0;
    w_in.rd        = e_q.rd;
    w_in.data      = e_q.is_cond ? '0 : alu_result;
    w_in.wen       = !e_q.is_cond && (e_q.rd != '0);
    w_in.br_taken  = e_q.is_cond && alu_result[0];
    w_in.br_target = e_q.is_cond ? (e_q.pc + e_q.imm) : '0;
  end

  alu_exec_stage_pipe_reg #(.T(w_data_t)) u_w_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (e_valid),
    .in_ready  (w_accept),
    .in_data   (w_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_q)
  );

  assign out_rd        = w_q.rd;
  assign out_data      = w_q.data;
  assign out_wen       = w_q.wen;
  assign out_br_taken  = w_q.br_taken;
  assign out_br_target = w_q.br_target;

  // Back-pressure monitor: E holds an op that W cannot take. Saturates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (e_valid && !w_accept && !flush && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage. A small behavioural ALU
// closes the loop from alu_a/alu_b/alu_op/alu_is_cond to alu_result.
module tb_alu_exec_stage;
  import alu_exec_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush;
  logic        in_valid, in_ready;
  logic [3:0]  in_op;
  logic        in_is_cond, in_use_imm;
  logic [31:0] in_rs1, in_rs2, in_imm, in_pc;
  logic [4:0]  in_rd;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;
  logic        alu_is_cond;
  logic        out_valid, out_ready, out_wen, out_br_taken;
  logic [4:0]  out_rd;
  logic [31:0] out_data, out_br_target;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_exec_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_is_cond(in_is_cond),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_use_imm(in_use_imm),
    .in_pc(in_pc), .in_rd(in_rd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_is_cond(alu_is_cond),
    .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_data(out_data),
    .out_wen(out_wen), .out_br_taken(out_br_taken), .out_br_target(out_br_target),
    .stall_cnt(stall_cnt)
  );

  // Stand-in for the external ALU.
  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_EQ:   return {31'd0, a == b};
      ALU_NE:   return {31'd0, a != b};
      default:  return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_model(alu_op, alu_a, alu_b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic is_cond, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm, input logic use_imm,
                       input logic [31:0] pc, input logic [4:0] rd);
    in_valid   = 1'b1;
    in_op      = op;
    in_is_cond = is_cond;
    in_rs1     = rs1;
    in_rs2     = rs2;
    in_imm     = imm;
    in_use_imm = use_imm;
    in_pc      = pc;
    in_rd      = rd;
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    in_op      = '0;
    in_is_cond = 1'b0;
    in_rs1     = '0;
    in_rs2     = '0;
    in_imm     = '0;
    in_use_imm = 1'b0;
    in_pc      = '0;
    in_rd      = '0;
  endtask

  // Back-pressure stream: SUB 10-3, AND F0F0&FF00, OR 1|2, XOR FF^0F.
  logic [3:0]  bp_op  [4] = '{ALU_SUB, ALU_AND, ALU_OR, ALU_XOR};
  logic [31:0] bp_a   [4] = '{32'd10, 32'h0000_F0F0, 32'h1, 32'hFF};
  logic [31:0] bp_b   [4] = '{32'd3,  32'h0000_FF00, 32'h2, 32'h0F};
  logic [31:0] bp_exp [4] = '{32'd7,  32'h0000_F000, 32'h3, 32'hF0};

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int send, recv, cyc;
    logic acc, fire;

    // Reset held 2 cycles while an op is offered.
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(ALU_ADD, 1'b0, 32'hDEAD, 32'hBEEF, 32'h0, 1'b0, 32'h0, 5'd7);
    repeat (2) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready,  1);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_alu_a",     alu_a,     0);
    check("rst_out_data",  out_data,  0);
    rst_n = 1'b1;
    idle();
    tick();
    check("rst_no_result", out_valid, 0);

    // ADD 5+7 -> rd 3.
    drive(ALU_ADD, 1'b0, 32'd5, 32'd7, 32'h0, 1'b0, 32'h0, 5'd3);
    tick(); idle();
    check("add_alu_a",     alu_a,     5);
    check("add_alu_b",     alu_b,     7);
    check("add_alu_op",    alu_op,    ALU_ADD);
    check("add_not_yet",   out_valid, 0);
    tick();
    check("add_out_valid", out_valid, 1);
    check("add_out_data",  out_data,  12);
    check("add_out_wen",   out_wen,   1);
    check("add_out_rd",    out_rd,    3);
    check("add_taken",     out_br_taken,  0);
    check("add_target",    out_br_target, 0);
    tick();
    check("add_drained",   out_valid, 0);

    // Immediate operand, rd=0 suppresses write.
    drive(ALU_ADD, 1'b0, 32'd1, 32'h55, 32'hFFFF_FFFF, 1'b1, 32'h0, 5'd0);
    tick(); idle();
    check("imm_alu_b",     alu_b,    32'hFFFF_FFFF);
    tick();
    check("imm_out_valid", out_valid, 1);
    check("imm_out_data",  out_data,  0);
    check("imm_out_wen",   out_wen,   0);
    tick();

    // Taken branch with wrapping target; use_imm ignored for compare.
    drive(ALU_EQ, 1'b1, 32'd9, 32'd9, 32'd8, 1'b1, 32'hFFFF_FFFC, 5'd0);
    tick(); idle();
    check("br_alu_b",      alu_b,       9);
    check("br_is_cond",    alu_is_cond, 1);
    tick();
    check("br_taken",      out_br_taken,  1);
    check("br_target",     out_br_target, 32'h4);
    check("br_data",       out_data,      0);
    check("br_wen",        out_wen,       0);
    tick();

    // Not-taken branch with rd!=0 and negative offset.
    drive(ALU_NE, 1'b1, 32'd9, 32'd9, 32'hFFFF_FFF0, 1'b0, 32'h100, 5'd5);
    tick(); idle();
    tick();
    check("bnt_valid",     out_valid,     1);
    check("bnt_taken",     out_br_taken,  0);
    check("bnt_target",    out_br_target, 32'hF0);
    check("bnt_wen",       out_wen,       0);
    check("bnt_data",      out_data,      0);
    tick();

    // Back-pressure: out_ready low until 5 stalled edges have elapsed.
    send = 0; recv = 0; cyc = 0;
    while (recv < 4 && cyc < 40) begin
      out_ready = (cyc >= 7);
      if (send < 4) drive(bp_op[send], 1'b0, bp_a[send], bp_b[send], 32'h0, 1'b0, 32'h0,
                          5'(send + 1));
      else idle();
      #1;
      acc  = in_valid && in_ready;
      fire = out_valid && out_ready;
      if (cyc >= 2 && cyc <= 6) begin
        check("bp_in_ready_low", in_ready,  0);
        check("bp_w_held_valid", out_valid, 1);
        check("bp_w_held_data",  out_data,  bp_exp[0]);
        check("bp_w_held_rd",    out_rd,    1);
      end
      if (cyc == 7) begin
        check("bp_stall_cnt",   stall_cnt, 5);
        check("bp_accepts",     send,      2);
      end
      if (fire) begin
        check("bp_data", out_data, bp_exp[recv]);
        check("bp_rd",   out_rd,   recv + 1);
        recv++;
      end
      tick();
      if (acc) send++;
      cyc++;
    end
    check("bp_all_results", recv, 4);
    check("bp_cycles",      cyc,  11);
    idle();
    out_ready = 1'b1;
    tick();
    check("bp_stall_hold", stall_cnt, 5);

    // Flush with E and W full and a new op offered.
    out_ready = 1'b0;
    drive(ALU_ADD, 1'b0, 32'd1, 32'd2, 32'h0, 1'b0, 32'h0, 5'd1);
    tick();
    drive(ALU_ADD, 1'b0, 32'd3, 32'd4, 32'h0, 1'b0, 32'h0, 5'd2);
    tick();
    check("fl_pre_valid", out_valid, 1);
    drive(ALU_ADD, 1'b0, 32'd5, 32'd6, 32'h0, 1'b0, 32'h0, 5'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    check("fl_out_valid", out_valid, 0);
    check("fl_in_ready",  in_ready,  1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl_no_result", out_valid, 0);
    end
    check("fl_stall_cnt", stall_cnt, 5);

    // Reset beats flush while both stages are full.
    out_ready = 1'b0;
    drive(ALU_OR, 1'b0, 32'hAAAA, 32'h5555, 32'h0, 1'b0, 32'h0, 5'd9);
    tick();
    drive(ALU_AND, 1'b0, 32'h1234, 32'h00FF, 32'h0, 1'b0, 32'h0, 5'd10);
    tick();
    check("rf_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    flush = 1'b1;
    tick();
    rst_n = 1'b1;
    flush = 1'b0;
    idle();
    check("rf_out_valid", out_valid, 0);
    check("rf_alu_a",     alu_a,     0);
    check("rf_alu_b",     alu_b,     0);
    check("rf_out_data",  out_data,  0);
    check("rf_out_rd",    out_rd,    0);
    check("rf_stall_cnt", stall_cnt, 0);
    check("rf_in_ready",  in_ready,  1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
